bit_serializer: RTL and testbench

- Parallel-in, serial-out stage that drives the serial bit input `w` of the downstream sequence detector, one bit per clock.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, with a bit-valid qualifier and an end-of-frame pulse.
- Back-to-back words stream with no idle bubble, so detector patterns that span word boundaries are preserved.

---
 rtl/serial_pkg.sv | 7 +
 rtl/bit_serializer.sv | 135 +++++++++++++
 tb/tb_bit_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared state encoding and default word width for the serial front end.
package serial_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] PARITY = 2'b10;
    localparam int DEFAULT_WIDTH  = 8;
endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage feeding the sequence detector's w input.
// Define BIT_SERIALIZER_PARITY_EN to append one even-parity bit per frame.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             frame_done
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_w;
    logic             r_w_valid;
    logic             r_frame_done;
    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_w_nxt;
    logic             w_vld_nxt;
    logic             w_fd_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // r_cnt is the index of the bit currently on w; zero marks the last data bit.
    assign w_last = (r_state == SHIFT) && (r_cnt == '0);

`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_ready = (r_state == IDLE) || (r_state == PARITY);
`else
    assign w_ready = (r_state == IDLE) || w_last;
`endif

    assign load_ready = ~reset & w_ready;
    assign w_accept   = load_valid & load_ready;
    assign busy       = (r_state != IDLE);
    assign w          = r_w;
    assign w_valid    = r_w_valid;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = w_accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so compute the value the next cycle should show.
    always_comb begin
        w_w_nxt   = 1'b0;
        w_vld_nxt = 1'b0;
        w_fd_nxt  = 1'b0;
        if (w_accept) begin
            w_w_nxt   = head_bit(din);
            w_vld_nxt = 1'b1;
        end else if ((r_state == SHIFT) && !w_last) begin
            w_w_nxt   = head_bit(r_shift);
            w_vld_nxt = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
            w_fd_nxt  = (r_cnt == CNT_W'(1));
`endif
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        else if (w_last) begin
            w_w_nxt   = r_parity;
            w_vld_nxt = 1'b1;
            w_fd_nxt  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_w          <= 1'b0;
            r_w_valid    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_w          <= w_w_nxt;
            r_w_valid    <= w_vld_nxt;
            r_frame_done <= w_fd_nxt;
            if (w_accept) begin
                r_shift  <= advance(din);
                r_cnt    <= CNT_W'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
                r_parity <= ^din;
`endif
            end else if ((r_state == SHIFT) && !w_last) begin
                r_shift  <= advance(r_shift);
                r_cnt    <= r_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances.
module tb_bit_serializer;
    typedef struct packed { logic b; logic fd; } exp_t;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FR = 8 + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lv0 = 1'b0, lv1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic rdy0, rdy1, w0, w1, wv0, wv1, busy0, busy1, fd0, fd1;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int run0 = 0, max_run0 = 0, rdyv0 = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u0 (
        .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(rdy0), .din(din0),
        .w(w0), .w_valid(wv0), .busy(busy0), .frame_done(fd0));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u1 (
        .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(rdy1), .din(din1),
        .w(w1), .w_valid(wv1), .busy(busy1), .frame_done(fd1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected bits are pushed at the accepting edge.
    task automatic push(input int s, input logic [7:0] d);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b  = (s == 0) ? d[7-i] : d[i];
            e.fd = (i == 7) && !PAR;
            if (s == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (PAR) begin
            e.b  = ^d;
            e.fd = 1'b1;
            if (s == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic send(input int s, input logic [7:0] d);
        int t;
        logic r;
        if (s == 0) begin lv0 = 1'b1; din0 = d; end
        else        begin lv1 = 1'b1; din1 = d; end
        t = 0;
        forever begin
            @(negedge clk);
            r = (s == 0) ? rdy0 : rdy1;
            @(posedge clk);
            if (r) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 8'd1, 8'd0);
                break;
            end
        end
        if (r) push(s, d);
        #1;
        if (s == 0) lv0 = 1'b0; else lv1 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", (t >= 200) ? 8'd1 : 8'd0, 8'd0);
    endtask

    task automatic mon(input int s, input logic w, input logic wv, input logic fd);
        exp_t e;
        if (wv) begin
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_bit%0d", s), 8'd1, 8'd0);
            end else begin
                e = (s == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("w%0d", s), {7'd0, w}, {7'd0, e.b});
                chk($sformatf("frame_done%0d", s), {7'd0, fd}, {7'd0, e.fd});
            end
        end else begin
            chk($sformatf("idle%0d", s), {6'd0, w, fd}, 8'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, w0, wv0, fd0);
            mon(1, w1, wv1, fd1);
        end
        if (wv0) begin
            run0++;
            if (run0 > max_run0) max_run0 = run0;
            if (rdy0) rdyv0++;
        end else begin
            run0 = 0;
        end
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_outputs", {4'd0, w0, wv0, fd0, busy0}, 8'd0);
        chk("rst_ready", {7'd0, rdy0}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("idle_ready", {6'd0, rdy0, rdy1}, 8'h03);
        chk("idle_busy", {6'd0, busy0, busy1}, 8'h00);

        // Single MSB-first frame and single LSB-first frame
        send(0, 8'hC6);
        drain();
        send(1, 8'h01);
        drain();

        // Back-to-back frames must form one contiguous run
        max_run0 = 0; rdyv0 = 0;
        send(0, 8'hA5);
        send(0, 8'h3C);
        drain();
        chk("b2b_run", 8'(max_run0), 8'(2 * FR));
        chk("b2b_ready_cnt", 8'(rdyv0), 8'd2);

        // Load while busy is ignored
        send(0, 8'h96);
        @(posedge clk); #1;
        lv0 = 1'b1; din0 = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        lv0 = 1'b0;
        drain();

        // Reset in cycle 4 of a frame aborts it
        send(0, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_ready_mid", {7'd0, rdy0}, 8'd0);
        @(posedge clk); #1;
        q0.delete();
        chk("abort_outputs", {5'd0, wv0, busy0, fd0}, 8'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {7'd0, rdy0}, 8'd1);
        send(0, 8'hFF);
        drain();

        send(0, 8'h07);
        drain();

        chk("q0_empty", 8'(q0.size()), 8'd0);
        chk("q1_empty", 8'(q1.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
